// File: rtl/fp_pkg.sv
// Shared constants, helpers and stage-record pieces for the pipelined FP add/sub unit.
// Helpers take the format widths as arguments so one package serves half, single and double.
package fp_pkg;

    localparam int EXP_W_SP  = 8;
    localparam int MAN_W_SP  = 23;
    localparam int TAG_W_DEF = 5;

    localparam int FLAG_W         = 3;
    localparam int FLAG_INVALID   = 2;
    localparam int FLAG_OVERFLOW  = 1;
    localparam int FLAG_UNDERFLOW = 0;

    typedef logic [63:0] fp_word_t;

    typedef enum logic [1:0] {
        SPC_NONE = 2'd0,
        SPC_NAN  = 2'd1,
        SPC_INF  = 2'd2
    } spc_e;

    typedef struct packed {
        spc_e kind;
        logic sign;
    } spc_t;

    function automatic int f_width(input int exp_w, input int man_w);
        return 1 + exp_w + man_w;
    endfunction

    function automatic int f_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    function automatic fp_word_t f_exp_ones(input int exp_w);
        return (64'd1 << exp_w) - 64'd1;
    endfunction

    function automatic fp_word_t f_qnan(input int exp_w, input int man_w);
        return (f_exp_ones(exp_w) << man_w) | (64'd1 << (man_w - 1));
    endfunction

    function automatic logic f_sign(input fp_word_t x, input int exp_w, input int man_w);
        return x[exp_w + man_w];
    endfunction

    function automatic fp_word_t f_exp(input fp_word_t x, input int exp_w, input int man_w);
        return (x >> man_w) & f_exp_ones(exp_w);
    endfunction

    function automatic fp_word_t f_man(input fp_word_t x, input int man_w);
        return x & ((64'd1 << man_w) - 64'd1);
    endfunction

endpackage

// File: rtl/fp_addsub_pipe_if.sv
// Operand/result handshake bundle of the FP add/sub pipeline.
// master is the issuing/consuming side, slave is the arithmetic unit.
interface fp_addsub_pipe_if
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 5
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic              in_valid;
    logic              in_ready;
    logic [W-1:0]      in_a;
    logic [W-1:0]      in_b;
    logic              in_sub;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [W-1:0]      out_result;
    logic [TAG_W-1:0]  out_tag;
    logic [FLAG_W-1:0] out_flags;

    modport master (
        output in_valid, in_a, in_b, in_sub, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag, out_flags
    );

    modport slave (
        input  in_valid, in_a, in_b, in_sub, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag, out_flags
    );
endinterface

// File: rtl/fp_lzc.sv
// Leading-zero counter; an all-zero input reports WIDTH.
module fp_lzc #(
    parameter int WIDTH = 28,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] value,
    output logic [CNT_W-1:0] count
);
    // Scan upward so the most significant set bit is the last writer
    always_comb begin
        count = CNT_W'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            count = value[i] ? CNT_W'(WIDTH - 1 - i) : count;
        end
    end
endmodule

// File: rtl/fp_addsub_pipe.sv
// Three-stage flush-to-zero FP add/subtract: align, add, normalise/round.
// All stages advance together whenever the output slot is empty or being drained.
module fp_addsub_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W = EXP_W_SP,
    parameter int MAN_W = MAN_W_SP,
    parameter int TAG_W = TAG_W_DEF
) (
    input logic             clk,
    input logic             rst,
    fp_addsub_pipe_if.slave bus
);
    localparam int W     = f_width(EXP_W, MAN_W);
    localparam int SIG_W = MAN_W + 4;   // hidden, mantissa, guard, round, sticky
    localparam int SUM_W = MAN_W + 5;
    localparam int CNT_W = $clog2(SUM_W + 1);
    localparam int XE_W  = EXP_W + 2;   // signed exponent with headroom both ways
    localparam logic [EXP_W-1:0]       EXP_ONES = EXP_W'(f_exp_ones(EXP_W));
    localparam logic [W-1:0]           QNAN     = W'(f_qnan(EXP_W, MAN_W));
    localparam logic signed [XE_W-1:0] X_ONE    = XE_W'(1);

    typedef struct packed {
        logic             valid;
        spc_t             spc;
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W:0]   sig_big;
        logic [SIG_W-1:0] sig_small;
        logic             eff_sub;
        logic [TAG_W-1:0] tag;
    } s1_t;

    typedef struct packed {
        logic             valid;
        spc_t             spc;
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [SUM_W-1:0] sum;
        logic [TAG_W-1:0] tag;
    } s2_t;

    logic adv_s;
    logic a_sign_s, b_sign_s, a_nan_s, b_nan_s, a_inf_s, b_inf_s, swap_s;
    logic [EXP_W-1:0] a_exp_s, b_exp_s, diff_s;
    logic [MAN_W-1:0] a_man_s, b_man_s;
    logic [EXP_W+MAN_W-1:0] a_key_s, b_key_s;
    logic [SIG_W-1:0] small_ext_s, small_sh_s, lost_s, norm_s;
    logic [SUM_W-1:0] sum_s;
    logic [CNT_W-1:0] lz_s;
    logic [MAN_W+1:0] mant_r_s;
    logic [MAN_W-1:0] man_out_s;
    logic signed [XE_W-1:0] exp_in_s, lz_x_s, exp_n_s, exp_r_s;
    logic round_up_s;
    logic [W-1:0] res_s;
    logic [FLAG_W-1:0] flags_s;
    s1_t s1_next_s, s1_r;
    s2_t s2_next_s, s2_r;
    logic out_valid_r;
    logic [W-1:0] out_result_r;
    logic [TAG_W-1:0] out_tag_r;
    logic [FLAG_W-1:0] out_flags_r;

    assign adv_s = !out_valid_r || bus.out_ready;

    assign a_sign_s = f_sign(64'(bus.in_a), EXP_W, MAN_W);
    assign b_sign_s = f_sign(64'(bus.in_b), EXP_W, MAN_W) ^ bus.in_sub;
    assign a_exp_s  = EXP_W'(f_exp(64'(bus.in_a), EXP_W, MAN_W));
    assign b_exp_s  = EXP_W'(f_exp(64'(bus.in_b), EXP_W, MAN_W));
    assign a_man_s  = MAN_W'(f_man(64'(bus.in_a), MAN_W));
    assign b_man_s  = MAN_W'(f_man(64'(bus.in_b), MAN_W));
    assign a_nan_s  = (a_exp_s == EXP_ONES) && (a_man_s != '0);
    assign b_nan_s  = (b_exp_s == EXP_ONES) && (b_man_s != '0);
    assign a_inf_s  = (a_exp_s == EXP_ONES) && (a_man_s == '0);
    assign b_inf_s  = (b_exp_s == EXP_ONES) && (b_man_s == '0);
    // Denormals compare as zero so the flushed operand is always the smaller one
    assign a_key_s  = (a_exp_s == '0) ? '0 : {a_exp_s, a_man_s};
    assign b_key_s  = (b_exp_s == '0) ? '0 : {b_exp_s, b_man_s};
    assign swap_s   = b_key_s > a_key_s;

    // Stage 1: classify specials, order by magnitude, align the smaller significand
    always_comb begin
        s1_next_s         = '0;
        s1_next_s.valid   = bus.in_valid;
        s1_next_s.tag     = bus.in_tag;
        s1_next_s.eff_sub = a_sign_s ^ b_sign_s;
        lost_s            = '0;
        if (swap_s) begin
            s1_next_s.sign    = b_sign_s;
            s1_next_s.exp     = b_exp_s;
            s1_next_s.sig_big = {1'b1, b_man_s};
            small_ext_s       = (a_exp_s == '0) ? '0 : {1'b1, a_man_s, 3'b000};
            diff_s            = b_exp_s - a_exp_s;
        end else begin
            s1_next_s.sign    = a_sign_s;
            s1_next_s.exp     = a_exp_s;
            s1_next_s.sig_big = (a_exp_s == '0) ? '0 : {1'b1, a_man_s};
            small_ext_s       = (b_exp_s == '0) ? '0 : {1'b1, b_man_s, 3'b000};
            diff_s            = a_exp_s - b_exp_s;
        end
        if (int'(diff_s) >= MAN_W + 3) begin
            small_sh_s = {{(SIG_W-1){1'b0}}, |small_ext_s};
        end else begin
            lost_s        = small_ext_s & ~({SIG_W{1'b1}} << diff_s);
            small_sh_s    = small_ext_s >> diff_s;
            small_sh_s[0] = small_sh_s[0] | (|lost_s);
        end
        s1_next_s.sig_small = small_sh_s;
        if (a_nan_s || b_nan_s || (a_inf_s && b_inf_s && (a_sign_s != b_sign_s))) begin
            s1_next_s.spc.kind = SPC_NAN;
            s1_next_s.spc.sign = 1'b0;
        end else if (a_inf_s) begin
            s1_next_s.spc.kind = SPC_INF;
            s1_next_s.spc.sign = a_sign_s;
        end else if (b_inf_s) begin
            s1_next_s.spc.kind = SPC_INF;
            s1_next_s.spc.sign = b_sign_s;
        end else begin
            s1_next_s.spc.kind = SPC_NONE;
            s1_next_s.spc.sign = 1'b0;
        end
    end

    // Stage 2: magnitude add or subtract; |big| >= |small| so the result is non-negative
    always_comb begin
        if (s1_r.eff_sub) begin
            sum_s = {1'b0, s1_r.sig_big, 3'b000} - {1'b0, s1_r.sig_small};
        end else begin
            sum_s = {1'b0, s1_r.sig_big, 3'b000} + {1'b0, s1_r.sig_small};
        end
        s2_next_s       = '0;
        s2_next_s.valid = s1_r.valid;
        s2_next_s.spc   = s1_r.spc;
        s2_next_s.exp   = s1_r.exp;
        s2_next_s.tag   = s1_r.tag;
        s2_next_s.sum   = sum_s;
        s2_next_s.sign  = (s1_r.eff_sub && (sum_s == '0)) ? 1'b0 : s1_r.sign;
    end

    fp_lzc #(.WIDTH(SUM_W), .CNT_W(CNT_W)) u_lzc (
        .value (s2_r.sum),
        .count (lz_s)
    );

    assign exp_in_s = $signed({2'b00, s2_r.exp});
    assign lz_x_s   = $signed(XE_W'(lz_s));

    // Stage 3: normalise, round to nearest even, then apply special-case overrides
    always_comb begin
        if (s2_r.sum[SUM_W-1]) begin
            norm_s  = {s2_r.sum[SUM_W-1:2], s2_r.sum[1] | s2_r.sum[0]};
            exp_n_s = exp_in_s + X_ONE;
        end else begin
            norm_s  = SIG_W'(s2_r.sum << (lz_s - CNT_W'(1)));
            exp_n_s = exp_in_s - lz_x_s + X_ONE;
        end
        round_up_s = norm_s[2] & (norm_s[1] | norm_s[0] | norm_s[3]);
        mant_r_s   = {1'b0, norm_s[SIG_W-1:3]} + (MAN_W+2)'(round_up_s);
        if (mant_r_s[MAN_W+1]) begin
            exp_r_s   = exp_n_s + X_ONE;
            man_out_s = mant_r_s[MAN_W:1];
        end else begin
            exp_r_s   = exp_n_s;
            man_out_s = mant_r_s[MAN_W-1:0];
        end
        flags_s = '0;
        res_s   = {s2_r.sign, exp_r_s[EXP_W-1:0], man_out_s};
        case (s2_r.spc.kind)
            SPC_NAN: begin
                res_s                 = QNAN;
                flags_s[FLAG_INVALID] = 1'b1;
            end
            SPC_INF: begin
                res_s = {s2_r.spc.sign, EXP_ONES, {MAN_W{1'b0}}};
            end
            default: begin
                if (s2_r.sum == '0) begin
                    res_s = {s2_r.sign, {(W-1){1'b0}}};
                end else if (exp_n_s <= $signed(XE_W'(0))) begin
                    res_s                   = {s2_r.sign, {(W-1){1'b0}}};
                    flags_s[FLAG_UNDERFLOW] = 1'b1;
                end else if (exp_r_s >= $signed({2'b00, EXP_ONES})) begin
                    res_s                  = {s2_r.sign, EXP_ONES, {MAN_W{1'b0}}};
                    flags_s[FLAG_OVERFLOW] = 1'b1;
                end else begin
                    res_s = {s2_r.sign, exp_r_s[EXP_W-1:0], man_out_s};
                end
            end
        endcase
    end

    // Stage registers and output slot; nothing moves while a result waits unaccepted
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_r         <= '0;
            s2_r         <= '0;
            out_valid_r  <= 1'b0;
            out_result_r <= '0;
            out_tag_r    <= '0;
            out_flags_r  <= '0;
        end else if (adv_s) begin
            s1_r         <= s1_next_s;
            s2_r         <= s2_next_s;
            out_valid_r  <= s2_r.valid;
            out_result_r <= res_s;
            out_tag_r    <= s2_r.tag;
            out_flags_r  <= flags_s;
        end
    end

    assign bus.in_ready   = adv_s;
    assign bus.out_valid  = out_valid_r;
    assign bus.out_result = out_result_r;
    assign bus.out_tag    = out_tag_r;
    assign bus.out_flags  = out_flags_r;
endmodule
